shift_register_sipo: RTL
========================

Name: shift_register_sipo

Overview:
- Serial-in/parallel-out receiver. Pairs with the team's parallel-in/serial-out shift register as the far end of the same single-wire serial link.
- Collects WIDTH serial bits, strobed by a bit-enable, into a word.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Provides frame re-alignment through `sync` and a sticky overrun flag.

Parameters:
- WIDTH, 5, number of bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = the first received bit lands in po[WIDTH-1]; 0 = the first received bit lands in po[0].

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, reset, synchronous and active-high.
- si, input, 1, serial data bit.
- si_en, input, 1, qualifies si; one bit is sampled per cycle while si_en=1.
- sync, input, 1, frame-alignment pulse; discards any partial word.
- po, output, WIDTH, parallel word; stable while po_valid=1.
- po_valid, output, 1, completed word available.
- po_ready, input, 1, consumer accepts po when po_valid and po_ready are both 1.
- busy, output, 1, a partial word is in progress (bit count > 0).
- overrun, output, 1, sticky; a completed word was dropped.

Behaviour:
- Reset (rst=1 at a clk edge): po=0, po_valid=0, busy=0, overrun=0, bit counter=0, shift register=0. Reset overrides every other input, including mid-word and while po_valid=1.
- Internal state:
  - sreg[WIDTH-1:0].
  - cnt, $clog2(WIDTH+1) bits, values 0..WIDTH-1.
  - Output holding register po.
  - po_valid flag.
  - overrun flag.
- Sampling, si_en=1:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], si}.
  - MSB_FIRST=0: sreg <= {si, sreg[WIDTH-1:1]}.
  - cnt <= cnt+1.
- Completion: si_en=1 with cnt==WIDTH-1. The assembled word, including the current si, is the completion word; cnt <= 0.
- Latency: po and po_valid update on the same edge that samples the last bit, so they are visible in the following cycle.
- Handshake:
  - po_valid stays high and po stays unchanged until a cycle with po_ready=1.
  - On that edge po_valid <= 0, unless a new completion occurs on the same edge.
  - po_ready while po_valid=0 is ignored.
- Completion while po_valid=0: load po, po_valid <= 1.
- Completion while po_valid=1 and po_ready=1 (simultaneous): load the new word into po, po_valid stays 1, no overrun.
- Completion while po_valid=1 and po_ready=0: the new word is dropped, po holds the old word, overrun <= 1.
- overrun is sticky and cleared only by rst.
- sync=1:
  - cnt <= 0 and the partial word is discarded.
  - If si_en=1 in the same cycle, that bit is taken as bit 0 of the new word (cnt <= 1).
  - sync never affects po, po_valid or overrun.
  - A completion cycle coinciding with sync is not a completion; sync wins.
- si_en=0: sreg and cnt hold.
- Bits may arrive with arbitrary gaps between them.
- busy = (cnt != 0), registered-equivalent (driven from the cnt flop).
- Back-to-back words with si_en held high continuously: one completion every WIDTH cycles with no lost bits.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - Default WIDTH constant, shared with the PISO transmitter so both ends agree.
  - MSB_FIRST default, also shared.
  - Count-width helper function.
- One sub-module is natural: sipo_bit_counter, a modulo-WIDTH counter with enable, sync-clear and a terminal-count output.
- Shift register, output register and flag logic stay in the top module.

Test Plan:
1. Basic word:
   - Stimulus: rst 2 cycles, then si_en=1 with si=1,0,1,1,1 on consecutive cycles, po_ready=0.
   - Required: po=5'b10111 and po_valid=1 in the cycle after the 5th bit; busy=1 after bits 1–4, then 0.
2. LSB-first:
   - Stimulus: MSB_FIRST=0, same bit sequence.
   - Required: po=5'b11101.
3. Gapped bits plus sync:
   - Stimulus: send 1,1 with si_en gaps, pulse sync, then send 0,0,1,1,0.
   - Required: po=5'b00110; the earlier partial word is lost; overrun=0.
4. Overrun:
   - Stimulus: po_ready=0; send 10111, then 01010.
   - Required: po stays 10111, po_valid=1, overrun=1 after the 10th bit.
   - Stimulus: then po_ready=1 for one cycle.
   - Required: po_valid=0, overrun remains 1.
5. Simultaneous accept and complete:
   - Stimulus: si_en continuous; send 10111 then 01010; assert po_ready exactly on the last-bit edge of the second word.
   - Required: po=01010, po_valid=1, overrun=0.
6. Reset mid-operation:
   - Stimulus: after 3 bits of a word with a prior word pending, assert rst for 1 cycle, then send 11001.
   - Required: po=0, po_valid=0, overrun=0 immediately after reset; then po=11001.

Source files
------------

// File: rtl/shift_register_sipo_pkg.sv
// rtl/shift_register_sipo_pkg.sv - shared constants and helpers for the serial link receiver
//
// Purpose: word width and bit order defaults shared with the PISO transmitter
//          so both ends of the single-wire link agree, plus the counter-width
//          helper used to size the bit counter.
// Ports:   none (package).
package shift_register_sipo_pkg;

  // Bits per serial word; the PISO transmitter uses the same default.
  localparam int SIPO_WIDTH_DEFAULT = 5;

  // 1: the first bit on the wire is the word MSB.
  localparam bit SIPO_MSB_FIRST_DEFAULT = 1'b1;

  // Bits needed to hold a count of 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_register_sipo_bit_counter.sv
// rtl/shift_register_sipo_bit_counter.sv - modulo-WIDTH bit counter with sync-clear
//
// Purpose: counts sampled serial bits within a word and flags the bit that
//          completes the word.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - a serial bit is sampled this cycle
//   clr  - frame re-alignment; restarts the word (this cycle's bit, if any,
//          becomes bit 0)
//   cnt  - bits already collected in the current word (0..WIDTH-1)
//   tc   - this cycle's bit completes a word (never while clr is high)
module sipo_bit_counter
  import shift_register_sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      // A bit arriving with the alignment pulse starts the new word.
      r_cnt <= en ? CW'(1) : '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign cnt = r_cnt;
  assign tc  = en & ~clr & (r_cnt == LAST);

endmodule

// File: rtl/shift_register_sipo.sv
// rtl/shift_register_sipo.sv - serial-in/parallel-out receiver with valid/ready output
//
// Purpose: assembles WIDTH serial bits (qualified by si_en) into a word and
//          presents it on a registered parallel output with a valid/ready
//          handshake, frame re-alignment via sync and a sticky overrun flag.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   si       - serial data bit
//   si_en    - si is sampled this cycle
//   sync     - frame alignment; discards any partial word
//   po       - completed word, stable while po_valid is high
//   po_valid - completed word available
//   po_ready - consumer takes po when po_valid and po_ready are both high
//   busy     - a partial word is in progress
//   overrun  - sticky; a completed word was dropped
module shift_register_sipo
  import shift_register_sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  input  logic             sync,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_po;
  logic             r_po_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sreg_next;
  logic [CW-1:0]    w_cnt;
  logic             w_complete;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (si_en),
    .clr (sync),
    .cnt (w_cnt),
    .tc  (w_complete)
  );

  // Shifted value including the current bit; on a completion cycle this is
  // the finished word. Stale bits left after sync are shifted out before the
  // next completion, so sreg itself needs no clearing.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sreg_next = {r_sreg[WIDTH-2:0], si};
    end else begin : g_lsb_first
      assign w_sreg_next = {si, r_sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg     <= '0;
      r_po       <= '0;
      r_po_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (si_en) begin
        r_sreg <= w_sreg_next;
      end

      if (w_complete) begin
        if (!r_po_valid || po_ready) begin
          // Empty holding register, or the old word leaves on this edge.
          r_po       <= w_sreg_next;
          r_po_valid <= 1'b1;
        end else begin
          // Consumer still holds the old word: drop the new one.
          r_overrun <= 1'b1;
        end
      end else if (r_po_valid && po_ready) begin
        r_po_valid <= 1'b0;
      end
    end
  end

  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign overrun  = r_overrun;
  assign busy     = (w_cnt != '0);

endmodule
